// File: rtl/elevator_car_model.sv
// Behavioural-but-synthesizable elevator car, shaft and door plant for closed-loop
// exercising of elevator_fsm: finite travel and door times, limit and conflict faults.
module elevator_car_model #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               motor_up,
    input  logic               motor_down,
    input  logic               open_door,
    input  logic               close_door,
    output logic [FLOOR_W-1:0] floor,
    output logic               at_floor,
    output logic               moving_up,
    output logic               moving_down,
    output logic               door_open_sw,
    output logic               door_closed_sw,
    output logic               cmd_fault
);

    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR   = {FLOOR_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_MOVE_UP      = 3'd1,
        S_MOVE_DN      = 3'd2,
        S_DOOR_OPENING = 3'd3,
        S_DOOR_OPEN    = 3'd4,
        S_DOOR_CLOSING = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [FLOOR_W-1:0]   r_floor;
    logic [FLOOR_W-1:0]   w_floor_next;
    logic                 r_fault;
    logic                 w_fault_next;
    logic                 w_illegal_idle;
    logic                 w_motor_any;
    logic                 r_at_floor;
    logic                 r_moving_up;
    logic                 r_moving_down;
    logic                 r_door_open_sw;
    logic                 r_door_closed_sw;

    assign w_motor_any    = motor_up | motor_down;
    assign w_illegal_idle = (motor_up & motor_down)
                          | (open_door & close_door)
                          | (open_door & w_motor_any)
                          | (motor_up & (r_floor == TOP_FLOOR))
                          | (motor_down & (r_floor == BOT_FLOOR));

    // Next-state, counter, floor and fault decision for the current sample
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = {CNT_W{1'b0}};
        w_floor_next = r_floor;
        w_fault_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_illegal_idle) begin
                    w_fault_next = 1'b1;
                end else if (open_door) begin
                    w_state_next = S_DOOR_OPENING;
                end else if (motor_up) begin
                    w_state_next = S_MOVE_UP;
                end else if (motor_down) begin
                    w_state_next = S_MOVE_DN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MOVE_UP: begin
                w_fault_next = open_door | close_door | motor_down;
                if (r_cnt == TRAVEL_LAST) begin
                    w_state_next = S_IDLE;
                    w_floor_next = r_floor + FLOOR_W'(1);
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_MOVE_DN: begin
                w_fault_next = open_door | close_door | motor_up;
                if (r_cnt == TRAVEL_LAST) begin
                    w_state_next = S_IDLE;
                    w_floor_next = r_floor - FLOOR_W'(1);
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DOOR_OPENING: begin
                w_fault_next = w_motor_any;
                if (r_cnt == DOOR_LAST) begin
                    w_state_next = S_DOOR_OPEN;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DOOR_OPEN: begin
                w_fault_next = w_motor_any;
                if (close_door) begin
                    w_state_next = S_DOOR_CLOSING;
                end else begin
                    w_state_next = S_DOOR_OPEN;
                end
            end
            S_DOOR_CLOSING: begin
                w_fault_next = w_motor_any;
                // A reopen request wins over a close completing on the same edge
                if (open_door) begin
                    w_state_next = S_DOOR_OPENING;
                end else if (r_cnt == DOOR_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, counter, floor and Moore outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= {CNT_W{1'b0}};
            r_floor          <= {FLOOR_W{1'b0}};
            r_fault          <= 1'b0;
            r_at_floor       <= 1'b1;
            r_moving_up      <= 1'b0;
            r_moving_down    <= 1'b0;
            r_door_open_sw   <= 1'b0;
            r_door_closed_sw <= 1'b1;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_floor          <= w_floor_next;
            r_fault          <= w_fault_next;
            r_at_floor       <= (w_state_next != S_MOVE_UP) && (w_state_next != S_MOVE_DN);
            r_moving_up      <= (w_state_next == S_MOVE_UP);
            r_moving_down    <= (w_state_next == S_MOVE_DN);
            r_door_open_sw   <= (w_state_next == S_DOOR_OPEN);
            r_door_closed_sw <= (w_state_next == S_IDLE) || (w_state_next == S_MOVE_UP)
                             || (w_state_next == S_MOVE_DN);
        end
    end

    assign floor          = r_floor;
    assign at_floor       = r_at_floor;
    assign moving_up      = r_moving_up;
    assign moving_down    = r_moving_down;
    assign door_open_sw   = r_door_open_sw;
    assign door_closed_sw = r_door_closed_sw;
    assign cmd_fault      = r_fault;

endmodule

// File: tb/tb_elevator_car_model.sv
// Self-checking bench: directed scenarios plus random commands, compared every cycle
// against a positional model of the car (ticks left to travel, door position 0..D).
module tb_elevator_car_model;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int T  = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          motor_up, motor_down, open_door, close_door;
    logic [FW-1:0] floor;
    logic          at_floor, moving_up, moving_down;
    logic          door_open_sw, door_closed_sw, cmd_fault;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: car travel ticks remaining plus direction, and door position with motion.
    int m_floor, m_tleft, m_dir, m_dpos, m_dact;
    bit m_fault;

    elevator_car_model #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset),
        .motor_up(motor_up), .motor_down(motor_down),
        .open_door(open_door), .close_door(close_door),
        .floor(floor), .at_floor(at_floor),
        .moving_up(moving_up), .moving_down(moving_down),
        .door_open_sw(door_open_sw), .door_closed_sw(door_closed_sw),
        .cmd_fault(cmd_fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_floor = 0; m_tleft = 0; m_dir = 0; m_dpos = 0; m_dact = 0; m_fault = 1'b0;
    endtask

    task automatic model_edge(input bit up, input bit dn, input bit op, input bit cl);
        m_fault = 1'b0;
        if (m_tleft > 0) begin
            if (op || cl || (m_dir > 0 ? dn : up)) m_fault = 1'b1;
            m_tleft--;
            if (m_tleft == 0) m_floor += m_dir;
        end else if (m_dact != 0 || m_dpos != 0) begin
            if (up || dn) m_fault = 1'b1;
            if (m_dact > 0) begin
                m_dpos++;
                if (m_dpos == D) m_dact = 0;
            end else if (m_dact < 0) begin
                if (op) begin
                    m_dpos = 0; m_dact = 1;
                end else begin
                    m_dpos--;
                    if (m_dpos == 0) m_dact = 0;
                end
            end else if (cl) begin
                m_dact = -1;
            end
        end else begin
            if ((up && dn) || (op && cl) || (op && (up || dn)) ||
                (up && m_floor == NF - 1) || (dn && m_floor == 0)) begin
                m_fault = 1'b1;
            end else if (op) begin
                m_dpos = 0; m_dact = 1;
            end else if (up) begin
                m_tleft = T; m_dir = 1;
            end else if (dn) begin
                m_tleft = T; m_dir = -1;
            end
        end
    endtask

    task automatic check_all();
        check_val("floor",          int'(floor),          m_floor);
        check_val("at_floor",       int'(at_floor),       int'(m_tleft == 0));
        check_val("moving_up",      int'(moving_up),      int'(m_tleft > 0 && m_dir > 0));
        check_val("moving_down",    int'(moving_down),    int'(m_tleft > 0 && m_dir < 0));
        check_val("door_open_sw",   int'(door_open_sw),   int'(m_dpos == D && m_dact == 0));
        check_val("door_closed_sw", int'(door_closed_sw), int'(m_dpos == 0 && m_dact == 0));
        check_val("cmd_fault",      int'(cmd_fault),      int'(m_fault));
    endtask

    task automatic step(input bit up, input bit dn, input bit op, input bit cl);
        motor_up = up; motor_down = dn; open_door = op; close_door = cl;
        @(posedge clk);
        model_edge(up, dn, op, cl);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        motor_up = 1'b0; motor_down = 1'b0; open_door = 1'b0; close_door = 1'b0;
        model_reset();
        #10;
        reset = 1'b0;
        check_val("rst_floor",  int'(floor), 0);
        check_val("rst_at",     int'(at_floor), 1);
        check_val("rst_closed", int'(door_closed_sw), 1);
        check_val("rst_others", int'({moving_up, moving_down, door_open_sw, cmd_fault}), 0);

        // Single one-cycle move up, then let it arrive
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (T) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("move1_floor", int'(floor), 1);

        // Hold up to the top, then keep pushing against the limit
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("top_floor", int'(floor), NF - 1);
        check_val("top_fault", int'(cmd_fault), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Conflicting command pairs in IDLE
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Door cycle with a motor request while open
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (D) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("door_opened", int'(door_open_sw), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (D) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("door_closed", int'(door_closed_sw), 1);

        // Reopen on the second cycle of closing
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (D) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (D) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reopen_open", int'(door_open_sw), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (D) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Down to floor 2, start up, reset asynchronously mid-travel
        repeat (T) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("pre_rst_floor", int'(floor), 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("arst_floor",  int'(floor), 0);
        check_val("arst_at",     int'(at_floor), 1);
        check_val("arst_moving", int'(moving_up), 0);
        check_val("arst_closed", int'(door_closed_sw), 1);
        model_reset();
        #3 reset = 1'b0;

        // Random command traffic, sparse and occasionally held
        begin
            bit up, dn, op, cl;
            up = 1'b0; dn = 1'b0; op = 1'b0; cl = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    up = ($urandom_range(0, 3) == 0);
                    dn = ($urandom_range(0, 3) == 0);
                    op = ($urandom_range(0, 4) == 0);
                    cl = ($urandom_range(0, 4) == 0);
                end
                step(up, dn, op, cl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
